keycode_dir_ctrl: RTL
=====================

KEYCODE_DIR_CTRL -- requirements
Module: keycode_dir_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- STABLE_FRAMES, default 2: consecutive identical samples needed to accept a key.
- TURN_HOLD, default 8: frames a buffered turn stays pending.
- STEP, default 1: motion magnitude per frame.
REQ-002 The block SHALL have one clock, frame_clk; reset is synchronous and active-high, named Reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  synchronous active-high reset.
- keycode  in  8  USB keycode sampled every edge.
- turn_ok  in  1  downstream mover says the pending direction is legal this frame.
- wall_hit  in  1  downstream mover says the current direction is blocked.
- cur_dir  out  3  current direction.
- pend_dir  out  3  buffered requested direction.
- X_Motion  out  10  two's-complement per-frame X step, registered.
- Y_Motion  out  10  two's-complement per-frame Y step, registered.
- turn_taken  out  1  one-cycle pulse when cur_dir changes to a nonzero value.

Function
REQ-004 Direction encoding SHALL be NONE=0, UP=1, LEFT=2, DOWN=3, RIGHT=4; codes 5-7 are never produced.
REQ-005 Keycodes SHALL map as 8'h1A->UP, 8'h04->LEFT, 8'h16->DOWN, 8'h07->RIGHT; every other code maps to NONE.
REQ-006 Debounce SHALL use a candidate register cand[2:0] and counter cnt:
- mapped dir d != NONE and d == cand: cnt increments, saturating at STABLE_FRAMES.
- d != NONE and d != cand: cand<=d, cnt<=1.
- d == NONE: cand<=NONE, cnt<=0.
REQ-007 A key SHALL be "accepted" on the edge where the updated cnt equals STABLE_FRAMES, and on every later edge while it stays saturated (held key).
REQ-008 When an accepted dir equals cur_dir, pend_dir SHALL be cleared to NONE and nothing else changes.
REQ-009 When an accepted dir equals the opposite of cur_dir (UP/DOWN, LEFT/RIGHT), it SHALL be applied immediately on that edge regardless of turn_ok: cur_dir<=dir, pend_dir<=NONE, turn_taken=1.
REQ-010 Any other accepted dir SHALL load pend_dir<=dir and hold_cnt<=TURN_HOLD; holding the key reloads hold_cnt every frame.
REQ-011 The FSM SHALL have three states:
- IDLE: cur_dir=NONE.
- MOVE: cur_dir!=NONE, pend_dir=NONE.
- PEND: pend_dir!=NONE.
REQ-012 In PEND with turn_ok=1, the next edge SHALL do cur_dir<=pend_dir, pend_dir<=NONE, turn_taken=1, and enter MOVE.
REQ-013 In PEND with turn_ok=0, hold_cnt SHALL decrement; on the edge where it reaches 0, pend_dir<=NONE and the state returns to MOVE, or to IDLE if cur_dir=NONE.
REQ-014 wall_hit=1 with no turn applied on that edge SHALL set cur_dir<=NONE; pend_dir is kept.
REQ-015 When wall_hit=1 and a turn (REQ-009 or REQ-012) occur on the same edge, the turn SHALL win.
REQ-016 When an accepted key and PEND with turn_ok=1 occur on the same edge, the old pend_dir SHALL be applied to cur_dir and the new key loaded into pend_dir. This applies only if the new key is not opposite to the new cur_dir; otherwise REQ-009 is applied next edge.
REQ-017 X_Motion and Y_Motion SHALL be registered from the next value of cur_dir, so they change on the same edge as cur_dir:
- UP: Y=-STEP (10'h3FF for STEP=1), X=0.
- DOWN: Y=+STEP, X=0.
- LEFT: X=-STEP, Y=0.
- RIGHT: X=+STEP, Y=0.
- NONE: both 0.
REQ-018 Latency SHALL be a key held on edges k..k+STABLE_FRAMES-1, accepted into pend_dir at edge k+STABLE_FRAMES-1, and applied no earlier than the next edge with turn_ok=1.
REQ-019 turn_taken SHALL be registered, high for exactly one frame per applied turn, and never high when cur_dir goes to NONE.

Reset
REQ-020 Reset=1 at a rising edge SHALL force cur_dir=0, pend_dir=0, cand=0, cnt=0, hold_cnt=0, X_Motion=0, Y_Motion=0, turn_taken=0, state=IDLE.
REQ-021 Reset SHALL override all other inputs, including mid-debounce and mid-PEND; the first post-reset edge needs a fresh STABLE_FRAMES-sample key.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, keycode=8'h07 for 2 edges, turn_ok=1 -> pend_dir=4 after edge 2, cur_dir=4 and X_Motion=10'd1 after edge 3, turn_taken pulses once.
- cur_dir=RIGHT, keycode=8'h04 for 2 edges, turn_ok=0 -> cur_dir=LEFT and X_Motion=10'h3FF at edge 2, with no pending state.
- cur_dir=RIGHT, key 8'h1A for 2 edges then released, turn_ok=0 for 8 frames -> pend_dir=1 for 8 frames then 0, cur_dir stays 4.
- Single-frame 8'h16 glitch between NONE codes -> cnt never reaches 2, pend_dir stays 0.
- cur_dir=UP, pending LEFT, wall_hit=1 and turn_ok=1 same edge -> cur_dir=2, turn_taken=1. Same with turn_ok=0 -> cur_dir=0, pend_dir=2.
- Reset asserted during PEND -> all outputs 0 next edge; a held key needs 2 fresh edges to be re-accepted.

Source files
------------

// File: rtl/keycode_dir_ctrl.sv
// keycode_dir_ctrl: debounces USB arrow keycodes, buffers a requested turn
// until the mover reports it legal (or it times out), and produces the
// current direction plus registered per-frame X/Y motion steps.
module keycode_dir_ctrl #(
    parameter int STABLE_FRAMES = 2,
    parameter int TURN_HOLD     = 8,
    parameter int STEP          = 1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       turn_ok,
    input  logic       wall_hit,
    output logic [2:0] cur_dir,
    output logic [2:0] pend_dir,
    output logic [9:0] X_Motion,
    output logic [9:0] Y_Motion,
    output logic       turn_taken
);

    localparam int CW_RAW = $clog2(STABLE_FRAMES + 1);
    localparam int HW_RAW = $clog2(TURN_HOLD + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_FRAMES);
    localparam logic [HW-1:0] HOLD_INIT = HW'(TURN_HOLD);
    localparam logic [9:0]    STEP_POS  = 10'(STEP);
    localparam logic [9:0]    STEP_NEG  = 10'(-STEP);

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_PEND
    } state_e;

    function automatic dir_e opposite_dir(input dir_e d);
        case (d)
            DIR_UP:    opposite_dir = DIR_DOWN;
            DIR_DOWN:  opposite_dir = DIR_UP;
            DIR_LEFT:  opposite_dir = DIR_RIGHT;
            DIR_RIGHT: opposite_dir = DIR_LEFT;
            default:   opposite_dir = DIR_NONE;
        endcase
    endfunction

    state_e        state_q, state_d;
    dir_e          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_e          cur_q, cur_d;
    dir_e          pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          turn_taken_q, turn_taken_d;

    dir_e key_dir;
    logic accepted;
    logic pend_apply;
    logic turn;

    // Translate the raw keycode into a direction request
    always_comb begin
        case (keycode)
            8'h1A:   key_dir = DIR_UP;
            8'h04:   key_dir = DIR_LEFT;
            8'h16:   key_dir = DIR_DOWN;
            8'h07:   key_dir = DIR_RIGHT;
            default: key_dir = DIR_NONE;
        endcase
    end

    // Debounce: a key counts as accepted once it has been seen STABLE_FRAMES
    // samples in a row, and again on every frame it stays held
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (key_dir == DIR_NONE) begin
            cand_d = DIR_NONE;
            cnt_d  = '0;
        end else if (key_dir == cand_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cand_d = key_dir;
            cnt_d  = CW'(1);
        end
        accepted = (key_dir != DIR_NONE) && (cnt_d == CNT_MAX);
    end

    // Next-state for direction, pending turn and motion. A pending turn is
    // applied first; the accepted key is then judged against the resulting
    // direction, and an opposite key arriving on that same edge waits one
    // frame (it is re-accepted while held). Any applied turn beats wall_hit.
    always_comb begin
        cur_d      = cur_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        turn       = 1'b0;
        pend_apply = (state_q == ST_PEND) && turn_ok;

        if (pend_apply) begin
            cur_d  = pend_q;
            pend_d = DIR_NONE;
            turn   = 1'b1;
        end else if (state_q == ST_PEND) begin
            if (hold_q <= HW'(1)) begin
                hold_d = '0;
                pend_d = DIR_NONE;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end

        if (accepted) begin
            if (key_dir == cur_d) begin
                pend_d = DIR_NONE;
            end else if (key_dir == opposite_dir(cur_d)) begin
                if (!pend_apply) begin
                    cur_d  = key_dir;
                    pend_d = DIR_NONE;
                    turn   = 1'b1;
                end
            end else begin
                pend_d = key_dir;
                hold_d = HOLD_INIT;
            end
        end

        if (wall_hit && !turn) begin
            cur_d = DIR_NONE;
        end

        if (pend_d != DIR_NONE) begin
            state_d = ST_PEND;
        end else if (cur_d != DIR_NONE) begin
            state_d = ST_MOVE;
        end else begin
            state_d = ST_IDLE;
        end

        x_d = '0;
        y_d = '0;
        case (cur_d)
            DIR_UP:    y_d = STEP_NEG;
            DIR_DOWN:  y_d = STEP_POS;
            DIR_LEFT:  x_d = STEP_NEG;
            DIR_RIGHT: x_d = STEP_POS;
            default: ;
        endcase

        turn_taken_d = turn;
    end

    // State registers with synchronous reset
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cand_q       <= DIR_NONE;
            cnt_q        <= '0;
            cur_q        <= DIR_NONE;
            pend_q       <= DIR_NONE;
            hold_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            turn_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            hold_q       <= hold_d;
            x_q          <= x_d;
            y_q          <= y_d;
            turn_taken_q <= turn_taken_d;
        end
    end

    assign cur_dir    = cur_q;
    assign pend_dir   = pend_q;
    assign X_Motion   = x_q;
    assign Y_Motion   = y_q;
    assign turn_taken = turn_taken_q;

endmodule
